fetch_unit: RTL

//  PC, MAR and instruction register (IR) of the 8-bit SAP-style CPU; sits directly upstream of
//  the control block and feeds it the opcode. Executes the fetch/address micro-ops driven by
//  the control word, drives the shared bus when enabled, flags bus contention, latches HALT.

---
 rtl/sap_pkg.sv | 45 ++++
 rtl/fetch_unit_program_counter.sv | 33 +++
 rtl/fetch_unit.sv | 112 +++++++++++
 3 files changed

// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-style 8-bit CPU: default widths, opcodes,
// control-word bit positions and the fetch unit's halt FSM states.
package sap_pkg;

  localparam int unsigned SAP_ADDR_W = 4;
  localparam int unsigned SAP_DATA_W = 8;
  localparam int unsigned OPCODE_W   = 4;
  localparam int unsigned CTRL_W     = 15;

  localparam logic [OPCODE_W-1:0] OP_HLT = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_NOP = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_LDA = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_OUT = 4'h5;
  localparam logic [OPCODE_W-1:0] OP_STA = 4'h6;
  localparam logic [OPCODE_W-1:0] OP_JMP = 4'h7;

  // Bit positions inside the control word produced by the control block.
  localparam int unsigned SIG_PC_INC      = 14;
  localparam int unsigned SIG_PC_EN       = 13;
  localparam int unsigned SIG_PC_LOAD     = 12;
  localparam int unsigned SIG_MAR_LOAD_N  = 11;
  localparam int unsigned SIG_RAM_EN_N    = 10;
  localparam int unsigned SIG_RAM_WE_N    = 9;
  localparam int unsigned SIG_IR_LOAD_N   = 8;
  localparam int unsigned SIG_IR_EN_N     = 7;
  localparam int unsigned SIG_A_LOAD_N    = 6;
  localparam int unsigned SIG_A_EN        = 5;
  localparam int unsigned SIG_ALU_SUB     = 4;
  localparam int unsigned SIG_ALU_EN      = 3;
  localparam int unsigned SIG_B_LOAD_N    = 2;
  localparam int unsigned SIG_FLAG_LOAD_N = 1;
  localparam int unsigned SIG_OUT_LOAD_N  = 0;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } halt_state_e;

  function automatic logic is_halt_opcode(input logic [OPCODE_W-1:0] op);
    return op == OP_HLT;
  endfunction

endpackage

// File: rtl/fetch_unit_program_counter.sv
// Program counter: load has priority over increment, increment wraps,
// freeze holds the value regardless of load/increment.
module program_counter
  import sap_pkg::*;
#(
  parameter int unsigned ADDR_W = SAP_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_inc,
  input  logic              i_freeze,
  input  logic [ADDR_W-1:0] i_load_val,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc <= '0;
    end else if (!i_freeze) begin
      if (i_load) begin
        r_pc <= i_load_val;
      end else if (i_inc) begin
        r_pc <= r_pc + ADDR_W'(1);
      end
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// PC, MAR and instruction register of the SAP CPU: executes fetch micro-ops,
// drives the shared bus, flags drive contention and latches HALT.
module fetch_unit
  import sap_pkg::*;
#(
  parameter int unsigned       ADDR_W = SAP_ADDR_W,
  parameter int unsigned       DATA_W = SAP_DATA_W,
  parameter logic [DATA_W-1:0] IR_RST = DATA_W'(8'h10)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ctrl_pc_inc,
  input  logic                ctrl_pc_en,
  input  logic                ctrl_pc_load,
  input  logic                ctrl_mar_load_n,
  input  logic                ctrl_ir_load_n,
  input  logic                ctrl_ir_en_n,
  input  logic [DATA_W-1:0]   bus_in,
  output logic [DATA_W-1:0]   bus_out,
  output logic                bus_drive,
  output logic [ADDR_W-1:0]   mar_addr,
  output logic [ADDR_W-1:0]   pc_value,
  output logic [OPCODE_W-1:0] opcode,
  output logic                halted,
  output logic                bus_conflict
);

  halt_state_e       r_state;
  halt_state_e       w_state_nxt;
  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_ir;
  logic              r_conflict;
  logic              w_run;
  logic              w_ir_load;
  logic [ADDR_W-1:0] w_pc;

  assign w_run     = (r_state == ST_RUN);
  assign w_ir_load = w_run && !ctrl_ir_load_n;

  program_counter #(
    .ADDR_W(ADDR_W)
  ) u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (ctrl_pc_load),
    .i_inc      (ctrl_pc_inc),
    .i_freeze   (!w_run),
    .i_load_val (bus_in[ADDR_W-1:0]),
    .o_pc       (w_pc)
  );

  // Halt FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // HALT is entered on the edge that loads an HLT opcode into IR.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_ir_load && is_halt_opcode(bus_in[DATA_W-1 -: OPCODE_W])) begin
          w_state_nxt = ST_HALT;
        end
      end
      ST_HALT: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mar      <= '0;
      r_ir       <= IR_RST;
      r_conflict <= 1'b0;
    end else begin
      if (!ctrl_mar_load_n) begin
        r_mar <= bus_in[ADDR_W-1:0];
      end
      if (w_ir_load) begin
        r_ir <= bus_in;
      end
      if (ctrl_pc_en && !ctrl_ir_en_n) begin
        r_conflict <= 1'b1;
      end
    end
  end

  // Bus mux: a simultaneous request from both sources drives nothing.
  always_comb begin
    bus_out   = '0;
    bus_drive = 1'b0;
    if (ctrl_pc_en && ctrl_ir_en_n) begin
      bus_out   = DATA_W'(w_pc);
      bus_drive = 1'b1;
    end else if (!ctrl_pc_en && !ctrl_ir_en_n) begin
      bus_out   = DATA_W'(r_ir[ADDR_W-1:0]);
      bus_drive = 1'b1;
    end
  end

  assign mar_addr     = r_mar;
  assign pc_value     = w_pc;
  assign opcode       = r_ir[DATA_W-1 -: OPCODE_W];
  assign halted       = (r_state == ST_HALT);
  assign bus_conflict = r_conflict;

endmodule
